// File: rtl/sbox_layer_pipe.sv
// ============================================================================
//  Module      : sbox_layer_pipe
//  Description : Two-stage valid/ready pipeline that substitutes every nibble
//                of a word through a 4-bit S-box (forward or inverse per word).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sbox_layer_pipe #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_inv,
   input  logic [WIDTH-1:0] in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int c_NIBBLES = WIDTH / 4;

   logic             r_s1_valid;
   logic             r_s1_inv;
   logic [WIDTH-1:0] r_s1_data;
   logic [TAG_W-1:0] r_s1_tag;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_s2_data;
   logic [TAG_W-1:0] r_s2_tag;

   logic             w_s2_load;
   logic             w_s1_load;
   logic [WIDTH-1:0] w_sub;

   function automatic logic [3:0] sbox_nib(input logic [3:0] x, input logic inv);
      logic [3:0] y;
      y = 4'h0;
      if (!inv) begin
         case (x)
            4'h0: y = 4'hA;  4'h1: y = 4'h5;  4'h2: y = 4'h8;  4'h3: y = 4'h2;
            4'h4: y = 4'h6;  4'h5: y = 4'hC;  4'h6: y = 4'h4;  4'h7: y = 4'h3;
            4'h8: y = 4'h1;  4'h9: y = 4'h0;  4'hA: y = 4'hB;  4'hB: y = 4'h9;
            4'hC: y = 4'hF;  4'hD: y = 4'hD;  4'hE: y = 4'h7;  4'hF: y = 4'hE;
         endcase
      end else begin
         case (x)
            4'h0: y = 4'h9;  4'h1: y = 4'h8;  4'h2: y = 4'h3;  4'h3: y = 4'h7;
            4'h4: y = 4'h6;  4'h5: y = 4'h1;  4'h6: y = 4'h4;  4'h7: y = 4'hE;
            4'h8: y = 4'h2;  4'h9: y = 4'hB;  4'hA: y = 4'h0;  4'hB: y = 4'hA;
            4'hC: y = 4'h5;  4'hD: y = 4'hD;  4'hE: y = 4'hF;  4'hF: y = 4'hC;
         endcase
      end
      return y;
   endfunction

   generate
      for (genvar k = 0; k < c_NIBBLES; k++) begin : g_nib
         assign w_sub[4*k +: 4] = sbox_nib(r_s1_data[4*k +: 4], r_s1_inv);
      end
   endgenerate

   // S2 frees up when empty or being drained; S1 frees up when moving into S2.
   assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
   assign in_ready  = !rst && (!r_s1_valid || w_s2_load);
   assign w_s1_load = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_inv   <= 1'b0;
         r_s1_data  <= '0;
         r_s1_tag   <= '0;
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_tag   <= '0;
      end else begin
         if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_data  <= w_sub;
            r_s2_tag   <= r_s1_tag;
         end else if (out_ready) begin
            r_s2_valid <= 1'b0;
         end

         if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_s1_inv   <= in_inv;
            r_s1_data  <= in_data;
            r_s1_tag   <= in_tag;
         end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_data  = r_s2_data;
   assign out_tag   = r_s2_tag;
   assign busy      = r_s1_valid || r_s2_valid;

endmodule

`default_nettype wire
